i2s_tx_fifo_mc: RTL and testbench
=================================

# i2s_tx_fifo_mc

Multi-line, FIFO-buffered I2S/left-justified serial audio transmitter, clocked from the audio master clock. It replaces per-sample frame resynchronisation with a free-running frame generator fed from a small sample FIFO. The FIFO decouples the upstream audio pipeline (valid/ready handshake) from the DAC/HDMI serial interface. It drives NUM_LINES parallel stereo data lines sharing one BCK/WS pair, and adds format select, mute and underflow reporting.

## Interface
- I2S_DATA_BITS, 24: bits per channel sample, MSB first; must be ≤ I2S_BCKS_PER_FRAME/2.
- I2S_BCKS_PER_FRAME, 64: BCK periods per stereo frame (32 or 64).
- MCLK_FRAME_DIVIDER, 256: AMCLK cycles per frame; power of 2, ≥ 2·I2S_BCKS_PER_FRAME.
- NUM_LINES, 1: stereo data lines (1–4).
- FIFO_DEPTH, 8: frames of buffering; power of 2, ≥ 2.

- AMCLK_i  in  1  audio master clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- APSDATA_i  in  NUM_LINES·2·I2S_DATA_BITS  frame word; line n left at [(2n+1)·W-1 : 2n·W], right at [(2n+2)·W-1 : (2n+1)·W], W = I2S_DATA_BITS.
- APDATA_VALID_i  in  1  frame word valid.
- APDATA_READY_o  out  1  FIFO can accept (= not full).
- fmt_lj_i  in  1  0 = I2S, 1 = left-justified.
- mute_i  in  1  transmit zeros, still consume FIFO.
- fifo_level_o  out  clog2(FIFO_DEPTH)+1  current occupancy.
- underflow_o  out  1  one-cycle pulse per starved frame.
- I2S_BCK  out  1  bit clock.
- I2S_WS  out  1  word select.
- I2S_DATA  out  NUM_LINES  serial data, one bit per line.

## Operation
- Frame counter ctr, MCLK_DIV_BITS wide, increments every cycle, wraps at MCLK_FRAME_DIVIDER. It is never resynchronised by input data.
- D = MCLK_FRAME_DIVIDER / I2S_BCKS_PER_FRAME. Slot k (0 … BCKS−1) spans ctr ∈ [k·D, (k+1)·D).
- BCK = ctr bit log2(D)−1: low in the first half of each slot, high in the second half. Data changes on BCK falling edges; the receiver samples on rising edges.
- WS, with I2S mode: 0 for the first half-frame (left), 1 for the second (right). With LJ mode the polarity is inverted (1 = left).
- Bit position: in LJ mode the left MSB occupies slot 0. In I2S mode it occupies slot 1 (one-BCK delay). The right MSB occupies slot BCKS/2 (LJ) or BCKS/2+1 (I2S). Channel bits follow MSB→LSB in successive slots. All remaining slots carry 0.
- Frame load happens at ctr = MCLK_FRAME_DIVIDER−1:
  - If the FIFO is non-empty, pop the head into the shift registers. If mute_i is high, load zeros instead (the pop still occurs).
  - If the FIFO is empty, load zeros and pulse underflow_o.
  - fmt_lj_i is latched at frame load. A mid-frame change takes effect at the next frame only.
- FIFO: push on APDATA_VALID_i & APDATA_READY_o. A push and a pop in the same cycle leave the level unchanged. A push into an empty FIFO in the load cycle is not bypassed: that frame underflows and the word is sent in the next frame.
- fifo_level_o reflects the registered occupancy after each cycle's push/pop.

## Timing
- I2S_BCK, I2S_WS and I2S_DATA are registered and computed from the same ctr value, so they are mutually aligned and lag ctr by one cycle.
- BCK period is D cycles with a 50 % duty cycle. WS toggles coincident with a BCK falling edge.
- Output ctr-slot 0 appears on the pins in the cycle after ctr = 0.
- Latency: a word pushed at cycle t, with the FIFO empty and t before the load cycle, loads at the next ctr = MCLK_FRAME_DIVIDER−1. Its left MSB is on the pins 1 cycle later (LJ) or D+1 cycles later (I2S).
- Reset values: ctr = 0, FIFO empty, fifo_level_o = 0, APDATA_READY_o = 0 during reset and 1 from the first cycle after, I2S_BCK = 0, I2S_WS = 0, I2S_DATA = 0, underflow_o = 0, latched format = I2S.
- The first frame after reset transmits zeros and does not pulse underflow_o. Reset mid-frame aborts the frame and flushes the FIFO.

## Test plan
- Defaults, 1 line, push L = 0xA5A5A5, R = 0x5A5A5A, I2S mode:
  - WS = 0 for 128 cycles, then 1 for 128 cycles; BCK period is 4 cycles.
  - Left MSB '1' appears in slot 1, right MSB '0' in slot 33.
  - Slots 25–31 are 0.
- Same word with fmt_lj_i = 1: WS = 1 during the left half; the left MSB is in slot 0.
- NUM_LINES = 2, distinct words per line: each I2S_DATA bit carries its own line's word in the same slots.
- Push 8 words back-to-back into an empty FIFO: READY drops after the 8th. Level reads 8 and decrements by 1 at each frame load. Output order matches push order.
- Stop pushing: the frame after the FIFO drains is all zeros, underflow_o pulses once at ctr = 255, and pulses again each starved frame.
- mute_i = 1 with 3 queued words: 3 zero frames are sent, level goes 3→0, and underflow_o is not pulsed. Assert reset at ctr = 100: all outputs return to their reset values the next cycle and the level reads 0.

Source files
------------

// File: rtl/i2s_tx_fifo_mc_if.sv
// Upstream sample-word channel into i2s_tx_fifo_mc: one frame word (all lines,
// left and right) per transfer.
interface i2s_tx_fifo_mc_if #(
    parameter int WORD_W = 48
);
    // A word transfers on every clock edge where APDATA_VALID_i and APDATA_READY_o
    // are both high; the source holds APSDATA_i stable while valid waits on ready.
    logic [WORD_W-1:0] APSDATA_i;
    logic              APDATA_VALID_i;
    logic              APDATA_READY_o;

    modport master (
        output APSDATA_i,
        output APDATA_VALID_i,
        input  APDATA_READY_o
    );

    modport slave (
        input  APSDATA_i,
        input  APDATA_VALID_i,
        output APDATA_READY_o
    );
endinterface

// File: rtl/i2s_tx_fifo_mc.sv
// FIFO-fed multi-line I2S / left-justified transmitter with a free-running
// frame generator clocked from the audio master clock.
module i2s_tx_fifo_mc #(
    parameter int I2S_DATA_BITS      = 24,
    parameter int I2S_BCKS_PER_FRAME = 64,
    parameter int MCLK_FRAME_DIVIDER = 256,
    parameter int NUM_LINES          = 1,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                          AMCLK_i,
    input  logic                          reset,
    i2s_tx_fifo_mc_if.slave               ap,
    input  logic                          fmt_lj_i,
    input  logic                          mute_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          underflow_o,
    output logic                          I2S_BCK,
    output logic                          I2S_WS,
    output logic [NUM_LINES-1:0]          I2S_DATA
);
    localparam int W             = I2S_DATA_BITS;
    localparam int WORD_W        = NUM_LINES * 2 * W;
    localparam int MCLK_DIV_BITS = $clog2(MCLK_FRAME_DIVIDER);
    localparam int D             = MCLK_FRAME_DIVIDER / I2S_BCKS_PER_FRAME;
    localparam int D_BITS        = $clog2(D);
    localparam int SLOT_BITS     = $clog2(I2S_BCKS_PER_FRAME);
    localparam int HALF          = I2S_BCKS_PER_FRAME / 2;
    localparam int PTR_BITS      = $clog2(FIFO_DEPTH);
    localparam int WB            = (W > 1) ? $clog2(W) : 1;

    // Frame counter: free-running, never resynchronised to incoming data.
    logic [MCLK_DIV_BITS-1:0] ctr;
    logic                     load;

    assign load = (ctr == MCLK_DIV_BITS'(MCLK_FRAME_DIVIDER - 1));

    always_ff @(posedge AMCLK_i) begin
        if (reset) begin
            ctr <= '0;
        end else begin
            ctr <= ctr + 1'b1;
        end
    end

    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   level;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;

    assign empty             = (level == '0);
    assign full              = (level == (PTR_BITS + 1)'(FIFO_DEPTH));
    assign ap.APDATA_READY_o = !reset && !full;
    assign push              = ap.APDATA_VALID_i && ap.APDATA_READY_o;
    // Empty is the registered state, so a word pushed in the load cycle waits a frame.
    assign pop               = load && !empty;
    assign fifo_level_o      = level;
    assign underflow_o       = load && empty && !reset;

    always_ff @(posedge AMCLK_i) begin
        if (push) begin
            mem[wr_ptr] <= ap.APSDATA_i;
        end
    end

    always_ff @(posedge AMCLK_i) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Word being transmitted this frame and the format it was latched with.
    logic [WORD_W-1:0] frame_q;
    logic              fmt_q;

    always_ff @(posedge AMCLK_i) begin
        if (reset) begin
            frame_q <= '0;
            fmt_q   <= 1'b0;
        end else if (load) begin
            fmt_q   <= fmt_lj_i;
            frame_q <= (empty || mute_i) ? '0 : mem[rd_ptr];
        end
    end

    logic [SLOT_BITS-1:0] slot;
    logic                 bck_d;
    logic                 ws_d;
    logic [NUM_LINES-1:0] data_d;
    int                   lpos;
    int                   rpos;
    logic                 l_in;
    logic                 r_in;
    logic [WB-1:0]        l_idx;
    logic [WB-1:0]        r_idx;

    assign slot  = ctr[MCLK_DIV_BITS-1:D_BITS];
    assign bck_d = ctr[D_BITS-1];
    assign ws_d  = slot[SLOT_BITS-1] ^ fmt_q;

    // Bit position within each channel; I2S places the MSB one slot late.
    always_comb begin
        lpos  = int'(slot) - (fmt_q ? 0 : 1);
        rpos  = lpos - HALF;
        l_in  = (lpos >= 0) && (lpos < W);
        r_in  = (rpos >= 0) && (rpos < W);
        l_idx = WB'(W - 1 - lpos);
        r_idx = WB'(W - 1 - rpos);
    end

    for (genvar n = 0; n < NUM_LINES; n++) begin : g_line
        logic [W-1:0] left_w;
        logic [W-1:0] right_w;

        assign left_w    = frame_q[2*n*W +: W];
        assign right_w   = frame_q[(2*n+1)*W +: W];
        assign data_d[n] = l_in ? left_w[l_idx] : (r_in ? right_w[r_idx] : 1'b0);
    end

    always_ff @(posedge AMCLK_i) begin
        if (reset) begin
            I2S_BCK  <= 1'b0;
            I2S_WS   <= 1'b0;
            I2S_DATA <= '0;
        end else begin
            I2S_BCK  <= bck_d;
            I2S_WS   <= ws_d;
            I2S_DATA <= data_d;
        end
    end
endmodule

// File: tb/tb_i2s_tx_fifo_mc.sv
// Directed bench for i2s_tx_fifo_mc: per-slot vector table for I2S/LJ framing,
// plus sequences for FIFO fill/drain, underflow, mute and mid-frame reset.
module tb_i2s_tx_fifo_mc;
    logic       AMCLK_i;
    logic       reset;
    logic       fmt_lj_i;
    logic       mute_i;

    logic [3:0] fifo_level_o;
    logic       underflow_o;
    logic       I2S_BCK;
    logic       I2S_WS;
    logic [0:0] I2S_DATA;

    logic [3:0] level2;
    logic       uf2;
    logic       bck2;
    logic       ws2;
    logic [1:0] data2;

    i2s_tx_fifo_mc_if #(.WORD_W(48)) ap1 ();
    i2s_tx_fifo_mc_if #(.WORD_W(96)) ap2 ();

    i2s_tx_fifo_mc u_dut (
        .AMCLK_i      (AMCLK_i),
        .reset        (reset),
        .ap           (ap1),
        .fmt_lj_i     (fmt_lj_i),
        .mute_i       (mute_i),
        .fifo_level_o (fifo_level_o),
        .underflow_o  (underflow_o),
        .I2S_BCK      (I2S_BCK),
        .I2S_WS       (I2S_WS),
        .I2S_DATA     (I2S_DATA)
    );

    i2s_tx_fifo_mc #(.NUM_LINES(2)) u_dut2 (
        .AMCLK_i      (AMCLK_i),
        .reset        (reset),
        .ap           (ap2),
        .fmt_lj_i     (fmt_lj_i),
        .mute_i       (mute_i),
        .fifo_level_o (level2),
        .underflow_o  (uf2),
        .I2S_BCK      (bck2),
        .I2S_WS       (ws2),
        .I2S_DATA     (data2)
    );

    // Clock / reset and reference frame position
    initial AMCLK_i = 1'b0;
    always #5 AMCLK_i = ~AMCLK_i;

    logic [7:0] tb_ctr;
    int         uf_count = 0;

    always @(posedge AMCLK_i) begin
        if (reset) tb_ctr <= 8'd0;
        else       tb_ctr <= tb_ctr + 8'd1;
        if (underflow_o) uf_count <= uf_count + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pins at tb_ctr == c+1 show the DUT's computation for ctr == c.
    task automatic wait_ctr(input logic [7:0] target);
        int n;
        n = 0;
        do begin
            @(posedge AMCLK_i);
            #1;
            n++;
        end while (tb_ctr != target && n < 600);
        if (tb_ctr != target) begin
            checks++;
            errors++;
            $display("FAIL wait_ctr: reached %0d expected %0d", tb_ctr, target);
        end
    endtask

    // Left channel of line 0 in LJ mode: bit i sits in slot i.
    task automatic capture_left(output logic [23:0] w);
        w = '0;
        for (int i = 0; i < 24; i++) begin
            wait_ctr(8'(4 * i + 3));
            w[23 - i] = I2S_DATA[0];
        end
    endtask

    task automatic push1(input logic [47:0] word);
        ap1.APSDATA_i      = word;
        ap1.APDATA_VALID_i = 1'b1;
        @(posedge AMCLK_i);
        #1;
        ap1.APDATA_VALID_i = 1'b0;
    endtask

    typedef struct {
        logic       lj;
        logic [7:0] c;
        logic       bck;
        logic       ws;
        logic       d;
        logic       chk2;
        logic [1:0] d2;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic lj, input logic [7:0] c, input logic bck, input logic ws,
                           input logic d, input logic chk2, input logic [1:0] d2);
        vec_t v;
        v.lj = lj; v.c = c; v.bck = bck; v.ws = ws; v.d = d; v.chk2 = chk2; v.d2 = d2;
        vecs.push_back(v);
    endtask

    task automatic run_vectors(input logic lj);
        foreach (vecs[i]) begin
            if (vecs[i].lj == lj) begin
                wait_ctr(vecs[i].c + 8'd1);
                check($sformatf("%s c=%0d bck", lj ? "lj" : "i2s", vecs[i].c), I2S_BCK, vecs[i].bck);
                check($sformatf("%s c=%0d ws", lj ? "lj" : "i2s", vecs[i].c), I2S_WS, vecs[i].ws);
                check($sformatf("%s c=%0d data", lj ? "lj" : "i2s", vecs[i].c), I2S_DATA[0], vecs[i].d);
                if (vecs[i].chk2)
                    check($sformatf("2line c=%0d data", vecs[i].c), data2, vecs[i].d2);
            end
        end
    endtask

    logic [23:0] got;
    logic [23:0] lw;
    logic [23:0] xw;
    int          uf_base;

    initial begin
        // I2S: L=A5A5A5 R=5A5A5A; line 1 of the 2-line DUT: L=123456 R=FEDCBA
        add_vec(0, 8'd0,   0, 0, 0, 1, 2'b00);
        add_vec(0, 8'd2,   1, 0, 0, 1, 2'b00);
        add_vec(0, 8'd4,   0, 0, 1, 1, 2'b01);
        add_vec(0, 8'd8,   0, 0, 0, 1, 2'b00);
        add_vec(0, 8'd12,  0, 0, 1, 1, 2'b01);
        add_vec(0, 8'd16,  0, 0, 0, 1, 2'b10);
        add_vec(0, 8'd96,  0, 0, 1, 1, 2'b01);
        add_vec(0, 8'd100, 0, 0, 0, 1, 2'b00);
        add_vec(0, 8'd124, 0, 0, 0, 1, 2'b00);
        add_vec(0, 8'd127, 1, 0, 0, 1, 2'b00);
        add_vec(0, 8'd128, 0, 1, 0, 1, 2'b00);
        add_vec(0, 8'd132, 0, 1, 0, 1, 2'b10);
        add_vec(0, 8'd136, 0, 1, 1, 1, 2'b11);
        add_vec(0, 8'd220, 0, 1, 1, 1, 2'b11);
        add_vec(0, 8'd224, 0, 1, 0, 1, 2'b00);
        add_vec(0, 8'd255, 1, 1, 0, 1, 2'b00);
        // LJ, same line-0 word
        add_vec(1, 8'd0,   0, 1, 1, 0, 2'b00);
        add_vec(1, 8'd4,   0, 1, 0, 0, 2'b00);
        add_vec(1, 8'd8,   0, 1, 1, 0, 2'b00);
        add_vec(1, 8'd92,  0, 1, 1, 0, 2'b00);
        add_vec(1, 8'd94,  1, 1, 1, 0, 2'b00);
        add_vec(1, 8'd96,  0, 1, 0, 0, 2'b00);
        add_vec(1, 8'd128, 0, 0, 0, 0, 2'b00);
        add_vec(1, 8'd132, 0, 0, 1, 0, 2'b00);
        add_vec(1, 8'd134, 1, 0, 1, 0, 2'b00);
        add_vec(1, 8'd216, 0, 0, 1, 0, 2'b00);
        add_vec(1, 8'd220, 0, 0, 0, 0, 2'b00);
        add_vec(1, 8'd255, 1, 0, 0, 0, 2'b00);

        reset = 1'b1;
        fmt_lj_i = 1'b0;
        mute_i = 1'b0;
        ap1.APSDATA_i = '0;
        ap1.APDATA_VALID_i = 1'b0;
        ap2.APSDATA_i = '0;
        ap2.APDATA_VALID_i = 1'b0;
        repeat (3) @(posedge AMCLK_i);
        #1;
        check("reset bck", I2S_BCK, 0);
        check("reset ws", I2S_WS, 0);
        check("reset data", I2S_DATA, 0);
        check("reset level", fifo_level_o, 0);
        check("reset ready", ap1.APDATA_READY_o, 0);
        check("reset underflow", underflow_o, 0);
        reset = 1'b0;
        #1;
        check("ready after reset", ap1.APDATA_READY_o, 1);

        // Frame 0: push one word into both DUTs, sent in frame 1 (I2S)
        ap1.APSDATA_i = {24'h5A5A5A, 24'hA5A5A5};
        ap1.APDATA_VALID_i = 1'b1;
        ap2.APSDATA_i = {24'hFEDCBA, 24'h123456, 24'h5A5A5A, 24'hA5A5A5};
        ap2.APDATA_VALID_i = 1'b1;
        @(posedge AMCLK_i);
        #1;
        ap1.APDATA_VALID_i = 1'b0;
        ap2.APDATA_VALID_i = 1'b0;
        check("level one word", fifo_level_o, 1);
        wait_ctr(8'd0);
        check("level after load", fifo_level_o, 0);
        run_vectors(1'b0);

        // Frame 2: format changes mid-frame, frame stays I2S; word sent LJ in frame 3
        fmt_lj_i = 1'b1;
        push1({24'h5A5A5A, 24'hA5A5A5});
        wait_ctr(8'd11);
        check("midframe fmt ws left", I2S_WS, 0);
        check("starved frame data", I2S_DATA, 0);
        wait_ctr(8'd129);
        check("midframe fmt ws right", I2S_WS, 1);
        wait_ctr(8'd0);
        run_vectors(1'b1);

        // Frame 4: fill FIFO back-to-back
        for (int k = 0; k < 8; k++) begin
            lw = 24'hC0FFEE ^ (24'(k) * 24'h13579B);
            ap1.APSDATA_i = {~lw, lw};
            ap1.APDATA_VALID_i = 1'b1;
            check($sformatf("ready before push %0d", k), ap1.APDATA_READY_o, 1);
            @(posedge AMCLK_i);
            #1;
            exp_q.push_back(lw);
            check($sformatf("level after push %0d", k), fifo_level_o, 32'(k + 1));
        end
        check("ready when full", ap1.APDATA_READY_o, 0);
        ap1.APSDATA_i = 48'hDEAD_BEEF_0000;
        @(posedge AMCLK_i);
        #1;
        ap1.APDATA_VALID_i = 1'b0;
        check("level full no push", fifo_level_o, 8);

        for (int j = 0; j < 8; j++) begin
            wait_ctr(8'd0);
            check($sformatf("drain level %0d", j), fifo_level_o, 32'(7 - j));
            capture_left(got);
            check($sformatf("drain word %0d", j), got, exp_q.pop_front());
        end

        // Drained: starved frames pulse underflow at ctr 255
        wait_ctr(8'd254);
        check("underflow before load", underflow_o, 0);
        wait_ctr(8'd255);
        check("underflow first starve", underflow_o, 1);
        wait_ctr(8'd0);
        check("underflow one cycle", underflow_o, 0);
        check("level empty", fifo_level_o, 0);
        capture_left(got);
        check("starved frame word", got, 0);
        wait_ctr(8'd255);
        check("underflow second starve", underflow_o, 1);

        // Mute with 3 queued words
        mute_i = 1'b1;
        @(posedge AMCLK_i);
        #1;
        uf_base = uf_count;
        push1({24'h111111, 24'hFFFFFF});
        push1({24'h222222, 24'hF0F0F0});
        push1({24'h333333, 24'hAAAAAA});
        check("mute level queued", fifo_level_o, 3);
        for (int j = 0; j < 3; j++) begin
            wait_ctr(8'd0);
            check($sformatf("mute level %0d", j), fifo_level_o, 32'(2 - j));
            capture_left(got);
            check($sformatf("mute word %0d", j), got, 0);
        end
        check("mute no underflow", 32'(uf_count - uf_base), 0);
        mute_i = 1'b0;

        // Push into empty FIFO during the load cycle: not bypassed
        xw = 24'h9C3E71;
        wait_ctr(8'd255);
        check("load-cycle underflow", underflow_o, 1);
        push1({24'h000000, xw});
        check("load-cycle level", fifo_level_o, 1);
        capture_left(got);
        check("load-cycle frame zero", got, 0);
        wait_ctr(8'd0);
        check("load-cycle popped", fifo_level_o, 0);
        capture_left(got);
        check("load-cycle word next frame", got, xw);

        // Reset at ctr 100 mid-frame with a word queued
        push1({24'h0F0F0F, 24'hF0F0F0});
        check("pre-reset level", fifo_level_o, 1);
        wait_ctr(8'd100);
        check("pre-reset ws", I2S_WS, 1);
        reset = 1'b1;
        @(posedge AMCLK_i);
        #1;
        check("midreset bck", I2S_BCK, 0);
        check("midreset ws", I2S_WS, 0);
        check("midreset data", I2S_DATA, 0);
        check("midreset level", fifo_level_o, 0);
        check("midreset ready", ap1.APDATA_READY_o, 0);
        check("midreset underflow", underflow_o, 0);
        reset = 1'b0;
        @(posedge AMCLK_i);
        #1;
        check("post-reset ready", ap1.APDATA_READY_o, 1);
        check("post-reset level", fifo_level_o, 0);
        wait_ctr(8'd11);
        check("post-reset fmt i2s ws", I2S_WS, 0);
        check("post-reset bck", I2S_BCK, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
